imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 141 ++++++++++++++
 tb/tb_imm_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder
//  Purpose  : Encodes a 32-bit constant as an ARM rot/imm8 or 12-bit offset.
//             Define IMM_ENCODER_FAST_EN for a single-cycle parallel search.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] value,
   input  logic        is_mem,
   output logic        busy,
   output logic        done,
   output logic        ok,
   output logic [11:0] imm12
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] value_q, value_d;
   logic        ok_q, ok_d;
   logic [11:0] imm12_q, imm12_d;

   logic        hit;
   logic        last;
   logic [3:0]  hit_rot;
   logic [7:0]  hit_imm8;

   function automatic logic [31:0] rotl2(input logic [31:0] v, input logic [3:0] r);
      logic [63:0] w;
      w = {v, v} << {r, 1'b0};
      return w[63:32];
   endfunction

`ifdef IMM_ENCODER_FAST_EN
   logic [31:0] cand;

   // Scan downward so the lowest matching rotation is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_rot  = 4'd0;
      hit_imm8 = 8'd0;
      cand     = 32'd0;
      for (int r = 15; r >= 0; r--) begin
         cand = rotl2(value_q, r[3:0]);
         if (cand[31:8] == 24'd0) begin
            hit      = 1'b1;
            hit_rot  = r[3:0];
            hit_imm8 = cand[7:0];
         end
      end
   end

   assign last = 1'b1;
`else
   logic [3:0]  rot_q, rot_d;
   logic [31:0] cand;

   assign cand     = rotl2(value_q, rot_q);
   assign hit      = (cand[31:8] == 24'd0);
   assign hit_rot  = rot_q;
   assign hit_imm8 = cand[7:0];
   assign last     = (rot_q == 4'd15);
   assign rot_d    = (state_q == SEARCH) ? rot_q + 4'd1 : 4'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rot_q <= 4'd0;
      end else begin
         rot_q <= rot_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         value_q <= 32'd0;
         ok_q    <= 1'b0;
         imm12_q <= 12'd0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         ok_q    <= ok_d;
         imm12_q <= imm12_d;
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      ok_d    = ok_q;
      imm12_d = imm12_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               value_d = value;
               if (is_mem) begin
                  // Offset form resolves at capture time, so no search pass is needed.
                  ok_d    = (value[31:12] == 20'd0);
                  imm12_d = (value[31:12] == 20'd0) ? value[11:0] : 12'd0;
                  state_d = DONE;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (hit) begin
               ok_d    = 1'b1;
               imm12_d = {hit_rot, hit_imm8};
               state_d = DONE;
            end else if (last) begin
               ok_d    = 1'b0;
               imm12_d = 12'd0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy  = (state_q == SEARCH);
   assign done  = (state_q == DONE);
   assign ok    = ok_q;
   assign imm12 = imm12_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder
//  Purpose  : Self-checking bench for imm_encoder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic [31:0] value  = 32'd0;
   logic        is_mem = 1'b0;
   logic        busy, done, ok;
   logic [11:0] imm12;

`ifdef IMM_ENCODER_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   imm_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .value (value),
      .is_mem(is_mem),
      .busy  (busy),
      .done  (done),
      .ok    (ok),
      .imm12 (imm12)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int e     = 0;

   function automatic logic [31:0] rol(input logic [31:0] v, input int s);
      if (s == 0) return v;
      return (v << s) | (v >> (32 - s));
   endfunction

   function automatic logic [31:0] decode(input logic [11:0] f);
      int r;
      r = f[11:8];
      return rol({24'd0, f[7:0]}, (32 - 2 * r) % 32);
   endfunction

   // d = edge offset from the accepting edge to the edge after which done is seen
   function automatic void model(input logic [31:0] v, input logic mem,
                                 output logic mok, output logic [11:0] mimm, output int d);
      logic [31:0] x;
      mok  = 1'b0;
      mimm = 12'd0;
      if (mem) begin
         d = 0;
         if (v < 32'd4096) begin
            mok  = 1'b1;
            mimm = v[11:0];
         end
      end else begin
         d = 16;
         for (int r = 0; r < 16; r++) begin
            x = rol(v, 2 * r);
            if (x < 32'd256) begin
               mok  = 1'b1;
               mimm = {r[3:0], x[7:0]};
               d    = r + 1;
               break;
            end
         end
         if (FAST) d = 1;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
      end
   endtask

   // Scoreboard state shared between the monitor and the final tally
   logic        pend  = 1'b0;
   int          E     = 0;
   int          D     = 0;
   logic        x_ok, x_mem;
   logic [11:0] x_imm;
   logic [31:0] x_val;
   logic        c_ok  = 1'b0;
   logic [11:0] c_imm = 12'd0;
   int          accepted = 0;
   int          seen     = 0;

   always @(posedge clk) begin
      logic was_idle;
      e++;
      if (!rst_n) begin
         if (pend && e <= E + D) accepted--;
         pend  = 1'b0;
         c_ok  = 1'b0;
         c_imm = 12'd0;
      end else begin
         was_idle = !pend;
         if (pend && e == E + D + 1) pend = 1'b0;
         if (was_idle && start) begin
            pend  = 1'b1;
            E     = e;
            x_val = value;
            x_mem = is_mem;
            model(value, is_mem, x_ok, x_imm, D);
            accepted++;
         end
         if (pend && e == E + D) begin
            c_ok  = x_ok;
            c_imm = x_imm;
         end
      end
      #1;
      check("busy", busy, pend && e < E + D);
      check("done", done, pend && e == E + D);
      if (!pend || e >= E + D) begin
         check("ok", ok, c_ok);
         check("imm12", imm12, c_imm);
      end
      if (pend && e == E + D && x_ok && !x_mem)
         check("decode", decode(imm12), x_val);
      if (done) seen++;
   end

   task automatic run_directed(input string nm, input logic [31:0] v, input logic m,
                               input logic eok, input logic [11:0] eimm, input int elat,
                               input logic hold);
      int c;
      c      = 0;
      start  = 1'b1;
      value  = v;
      is_mem = m;
      while (c < 40) begin
         @(posedge clk);
         c++;
         #2;
         if (c == 1 && !hold) start = 1'b0;
         if (hold) value = $urandom;
         if (done) break;
      end
      check({nm, "_lat"}, c, elat);
      check({nm, "_ok"}, ok, eok);
      check({nm, "_imm"}, imm12, eimm);
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pin_model(input string nm, input logic [31:0] v, input logic m,
                            input logic eok, input logic [11:0] eimm);
      logic        o;
      logic [11:0] i;
      int          d;
      model(v, m, o, i, d);
      check({nm, "_ok"}, o, eok);
      check({nm, "_imm"}, i, eimm);
   endtask

   initial begin
      logic [31:0] v;
      pin_model("pin_ff",       32'h000000FF, 1'b0, 1'b1, 12'h0FF);
      pin_model("pin_ff000000", 32'hFF000000, 1'b0, 1'b1, 12'h4FF);
      pin_model("pin_f00f",     32'hF000000F, 1'b0, 1'b1, 12'h2FF);
      pin_model("pin_101",      32'h00000101, 1'b0, 1'b0, 12'h000);
      pin_model("pin_mem_abc",  32'h00000ABC, 1'b1, 1'b1, 12'hABC);

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ok", ok, 0);
      check("rst_imm", imm12, 0);

      // Start is presented on the same negedge reset is released
      rst_n = 1'b1;
      run_directed("ff",       32'h000000FF, 1'b0, 1'b1, 12'h0FF, 2, 1'b0);
      run_directed("ff000000", 32'hFF000000, 1'b0, 1'b1, 12'h4FF, FAST ? 2 : 6, 1'b0);
      run_directed("f000000f", 32'hF000000F, 1'b0, 1'b1, 12'h2FF, FAST ? 2 : 4, 1'b0);
      run_directed("v101",     32'h00000101, 1'b0, 1'b0, 12'h000, FAST ? 2 : 17, 1'b0);
      run_directed("mem_abc",  32'h00000ABC, 1'b1, 1'b1, 12'hABC, 1, 1'b0);
      run_directed("mem_1000", 32'h00001000, 1'b1, 1'b0, 12'h000, 1, 1'b0);
      run_directed("zero_dp",  32'h00000000, 1'b0, 1'b1, 12'h000, 2, 1'b0);
      run_directed("zero_mem", 32'h00000000, 1'b1, 1'b1, 12'h000, 1, 1'b0);
      run_directed("ff_again", 32'h000000FF, 1'b0, 1'b1, 12'h0FF, 2, 1'b0);

      // Reset in the middle of a search
      start = 1'b1;
      value = 32'h00000101;
      is_mem = 1'b0;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_ok", ok, 0);
      check("midrst_imm", imm12, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      run_directed("post_rst", 32'hFF000000, 1'b0, 1'b1, 12'h4FF, FAST ? 2 : 6, 1'b0);

      // Start held through the search while value keeps changing
      run_directed("hold_101", 32'h00000101, 1'b0, 1'b0, 12'h000, FAST ? 2 : 17, 1'b1);
      run_directed("hold_3fc", 32'h000003FC, 1'b0, 1'b1, 12'hFFF, FAST ? 2 : 17, 1'b1);

      for (int n = 0; n < 2500; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_busy", busy, 0);
            check("rnd_rst_done", done, 0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            start  = ($urandom_range(0, 2) == 0);
            is_mem = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
               0: v = 32'd0;
               1: v = rol({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
               2: v = $urandom;
               3: v = $urandom_range(0, 8191);
               default: v = rol({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15) + 1);
            endcase
            value = v;
         end
      end
      start = 1'b0;
      repeat (30) @(negedge clk);
      check("done_count", seen, accepted);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
